// File: rtl/dataproc_uart_rx.sv
// dataproc_uart_rx: 8N1 serial receiver (LSB first, idle high) feeding a small
// byte FIFO with a valid/ready output. Bit period is taken from cfg_div, clamped
// up to MIN_DIV and latched at start-bit detection.
module dataproc_uart_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_DIV    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ser_rx,
    input  logic [31:0] cfg_div,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_frame_err,
    output logic        rx_overrun,
    output logic        rx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t      state, state_n;
    logic        sync1, rx_s;
    logic [31:0] div_eff, div_q, div_q_n, cnt, cnt_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shreg, shreg_n;
    logic        byte_done, frame_err;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, rd_n;
    logic        empty, full, pop, push, overrun;

    // Two-flop synchroniser; both flops reset to the idle (high) line level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= ser_rx;
            rx_s  <= sync1;
        end
    end

    assign div_eff = (cfg_div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : cfg_div;

    // FSM and bit-timing registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            div_q   <= 32'(MIN_DIV);
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_q   <= div_q_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
        end
    end

    // Next-state: half a bit period to the start-bit centre, then whole periods
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_q_n   = div_q;
        bit_n     = bit_idx;
        shreg_n   = shreg;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    div_q_n = div_eff;
                    cnt_n   = (div_eff >> 1) - 32'd1;
                end
            end
            S_START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 32'd1;
                end else if (rx_s) begin
                    state_n = S_IDLE;          // false start
                end else begin
                    state_n = S_DATA;
                    bit_n   = '0;
                    cnt_n   = div_q - 32'd1;
                end
            end
            S_DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 32'd1;
                end else begin
                    shreg_n = {rx_s, shreg[7:1]};
                    cnt_n   = div_q - 32'd1;
                    if (bit_idx == 3'd7) state_n = S_STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 32'd1;
                end else if (rx_s) begin
                    byte_done = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    frame_err = 1'b1;
                    state_n   = S_WAIT_HIGH;   // ride out a break without restarting
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FIFO status; a same-cycle pop frees the slot for a push into a full FIFO
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && rx_ready;
    assign push    = byte_done && (!full || pop);
    assign overrun = byte_done && full && !pop;
    assign rd_n    = rd_ptr + (AW+1)'(pop);

    // Byte storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    // Pointers and registered head: a push landing on the new head slot bypasses the array
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rx_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            rd_ptr <= rd_n;
            if (push && (wr_ptr[AW-1:0] == rd_n[AW-1:0])) rx_data <= shreg;
            else if (pop)                                 rx_data <= mem[rd_n[AW-1:0]];
        end
    end

    assign rx_valid     = !empty;
    assign rx_frame_err = frame_err;
    assign rx_overrun   = overrun;
    assign rx_busy      = (state != S_IDLE);
endmodule
